noise_gate: RTL and testbench
=============================

NOISE_GATE -- requirements
Module: noise_gate

Interface
REQ-001 SHALL have parameter HOLD_SAMPLES, default 480, meaning accepted samples held open after the envelope falls below the close threshold (10 ms at 48 kHz).
REQ-002 SHALL have parameter ATTACK_STEP, default 32, meaning the gain increment per accepted sample while opening.
REQ-003 SHALL have parameter RELEASE_STEP, default 1, meaning the gain decrement per accepted sample while closing.
REQ-004 SHALL have parameter ENV_SHIFT, default 4, meaning the envelope smoothing shift.
REQ-005 SHALL have port i_clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port i_rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port i_level  input  3  gate setting from the top-level effect state register (state_gate); 0 = bypass.
REQ-008 SHALL have port i_valid  input  1  upstream sample valid.
REQ-009 SHALL have port i_sample  input  16  signed two's-complement input sample.
REQ-010 SHALL have port o_ready  output  1  block can accept a sample this cycle.
REQ-011 SHALL have port o_valid  output  1  output sample valid.
REQ-012 SHALL have port o_sample  output  16  signed gated sample.
REQ-013 SHALL have port i_ready  input  1  downstream ready.
REQ-014 SHALL have port o_gate_open  output  1  high while the FSM is in ATTACK, OPEN or HOLD.

Function
REQ-015 SHALL accept a sample when i_valid && o_ready; o_ready = !o_valid || i_ready; o_valid SHALL rise the cycle after acceptance (latency 1) and hold o_sample stable until i_ready.
REQ-016 SHALL update the envelope only on accept: a = |i_sample| (-32768 saturates to 32767); env += (a - env) >>> ENV_SHIFT, env 16-bit unsigned, signed 17-bit difference.
REQ-017 SHALL derive the open threshold thr = 32 << i_level (64..4096) and the close threshold thr - (thr >> 2).
REQ-018 SHALL implement FSM states CLOSED, ATTACK, OPEN, HOLD, RELEASE; transitions and gain changes occur only on accepted samples; comparisons use the pre-update envelope.
REQ-019 SHALL from CLOSED: go to ATTACK if env >= thr; gain is 0.
REQ-020 SHALL from ATTACK: add ATTACK_STEP to gain, saturating at 256; go to OPEN when the result is 256.
REQ-021 SHALL from OPEN: go to HOLD with hold_cnt = HOLD_SAMPLES-1 if env < close threshold.
REQ-022 SHALL from HOLD: return to OPEN if env >= thr; else go to RELEASE when hold_cnt == 0; else decrement hold_cnt.
REQ-023 SHALL from RELEASE: go to ATTACK if env >= thr; else subtract RELEASE_STEP from gain, saturating at 0, and go to CLOSED when the result is 0.
REQ-024 SHALL compute o_sample = (i_sample * gain) >>> 8 as a 25-bit signed product, using the gain value before that sample's update; gain 256 SHALL pass the sample bit-exact.
REQ-025 SHALL, when i_level == 0 at acceptance, force the state to OPEN and gain to 256 and pass the sample unchanged; the envelope keeps tracking.
REQ-026 SHALL, on a nonzero i_level change, use the new thresholds from the next accepted sample without resetting state, gain or hold_cnt.
REQ-027 SHALL, with i_valid high and i_ready low, stall: no acceptance and no state, gain, envelope or hold changes.

Reset
REQ-028 SHALL on i_rst: state CLOSED, gain 0, env 0, hold_cnt 0, o_valid 0, o_sample 0, o_gate_open 0; o_ready is 1 in the first cycle after reset.
REQ-029 SHALL let reset asserted mid-transfer discard the pending output sample without presenting it.

Structure
REQ-030 SHALL place the gate_state_e enum, the threshold base 32 and the unity gain 256 in shared package dcfx_pkg, alongside the EFF_* effect selectors.
REQ-031 SHALL place the envelope follower (REQ-016) in sub-module env_follower, with accept strobe, sample in, and env out.

Verification
REQ-032 SHALL cover: i_level=0, sample stream 1000, -32768 -> output identical, 1 cycle later, o_gate_open=1.
REQ-033 SHALL cover: i_level=1, constant 2000 -> env crosses 64 and then ATTACK for 8 samples (gain 32..256), then OPEN; output ramps to 2000.
REQ-034 SHALL cover: from OPEN with i_level=1, input drops to 0 -> env falls below 48, then HOLD for 480 samples, then RELEASE for 256 samples, then CLOSED, output 0.
REQ-035 SHALL cover: a burst of 2000 during HOLD returns the FSM to OPEN, hold_cnt never reaches 0, and gain stays 256.
REQ-036 SHALL cover: i_ready held low 5 cycles with i_valid high -> o_sample stable, o_ready=0, env unchanged; one sample accepted per i_ready cycle afterwards.
REQ-037 SHALL cover: i_rst pulsed during ATTACK -> next cycle o_valid=0, gain 0, state CLOSED.

Source files
------------

// File: rtl/dcfx_pkg.sv
// Shared definitions for the effects chain: effect selectors, gate FSM states and gate constants.
package dcfx_pkg;

    localparam logic [2:0] EFF_NONE  = 3'd0;
    localparam logic [2:0] EFF_GATE  = 3'd1;
    localparam logic [2:0] EFF_COMP  = 3'd2;
    localparam logic [2:0] EFF_DRIVE = 3'd3;
    localparam logic [2:0] EFF_DELAY = 3'd4;

    typedef enum logic [2:0] {
        GateClosed,
        GateAttack,
        GateOpen,
        GateHold,
        GateRelease
    } gate_state_e;

    localparam int unsigned GateThrBase = 32;
    localparam int unsigned GateUnity   = 256;

    // Level 1..7 maps to 64..4096; level 0 is bypass and its value is never compared.
    function automatic logic [15:0] gate_open_thr(input logic [2:0] level);
        return 16'(GateThrBase << level);
    endfunction

endpackage

// File: rtl/env_follower.sv
// One-pole envelope follower on |sample|, advanced only on accepted samples.
module env_follower #(
    parameter int unsigned ENV_SHIFT = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_accept,
    input  logic signed [15:0] i_sample,
    output logic [15:0]        o_env
);

    logic [15:0]        env_q, env_d;
    logic [15:0]        mag;
    logic signed [16:0] diff;
    logic signed [16:0] step;

    always_comb begin
        if (i_sample == 16'sh8000) begin
            mag = 16'h7fff;
        end else if (i_sample[15]) begin
            mag = ~i_sample + 16'd1;
        end else begin
            mag = i_sample;
        end
        diff  = $signed({1'b0, mag}) - $signed({1'b0, env_q});
        // Arithmetic shift floors, so a silent input decays the envelope all the way to 0.
        step  = diff >>> ENV_SHIFT;
        env_d = env_q;
        if (i_accept) begin
            env_d = env_q + 16'(step);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            env_q <= '0;
        end else begin
            env_q <= env_d;
        end
    end

    assign o_env = env_q;

endmodule

// File: rtl/noise_gate.sv
// Noise gate with hysteresis, hold and attack/release gain ramps on a valid/ready sample stream.
module noise_gate
    import dcfx_pkg::*;
#(
    parameter int unsigned HOLD_SAMPLES = 480,
    parameter int unsigned ATTACK_STEP  = 32,
    parameter int unsigned RELEASE_STEP = 1,
    parameter int unsigned ENV_SHIFT    = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [2:0]         i_level,
    input  logic               i_valid,
    input  logic signed [15:0] i_sample,
    output logic               o_ready,
    output logic               o_valid,
    output logic signed [15:0] o_sample,
    input  logic               i_ready,
    output logic               o_gate_open
);

    localparam int unsigned HoldW = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
    localparam logic [8:0]  Unity = 9'(GateUnity);

    gate_state_e        state_q, state_d;
    logic [8:0]         gain_q, gain_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic               valid_q, valid_d;
    logic signed [15:0] sample_q, sample_d;
    logic               gate_open_q, gate_open_d;

    logic               accept;
    logic [15:0]        env;
    logic [15:0]        thr_open, thr_close;
    logic [8:0]         gain_used;
    logic signed [24:0] prod;
    logic [31:0]        gain_sum;

    assign o_ready   = !valid_q || i_ready;
    assign accept    = i_valid && o_ready;
    assign thr_open  = gate_open_thr(i_level);
    assign thr_close = thr_open - (thr_open >> 2);

    env_follower #(
        .ENV_SHIFT(ENV_SHIFT)
    ) u_env (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_accept (accept),
        .i_sample (i_sample),
        .o_env    (env)
    );

    // Output stage scales by the gain in force before this sample's FSM update.
    always_comb begin
        gain_used = (i_level == 3'd0) ? Unity : gain_q;
        prod      = $signed({{9{i_sample[15]}}, i_sample}) * $signed({16'd0, gain_used});
        valid_d   = valid_q;
        sample_d  = sample_q;
        if (accept) begin
            valid_d  = 1'b1;
            sample_d = 16'(prod >>> 8);
        end else if (i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d  = state_q;
        gain_d   = gain_q;
        hold_d   = hold_q;
        gain_sum = 32'(gain_q) + ATTACK_STEP;
        if (accept) begin
            if (i_level == 3'd0) begin
                state_d = GateOpen;
                gain_d  = Unity;
            end else begin
                unique case (state_q)
                    GateClosed: begin
                        gain_d = '0;
                        if (env >= thr_open) state_d = GateAttack;
                    end
                    GateAttack: begin
                        if (gain_sum >= 32'(GateUnity)) begin
                            gain_d  = Unity;
                            state_d = GateOpen;
                        end else begin
                            gain_d = 9'(gain_sum);
                        end
                    end
                    GateOpen: begin
                        if (env < thr_close) begin
                            state_d = GateHold;
                            hold_d  = HoldW'(HOLD_SAMPLES - 1);
                        end
                    end
                    GateHold: begin
                        if (env >= thr_open) begin
                            state_d = GateOpen;
                        end else if (hold_q == '0) begin
                            state_d = GateRelease;
                        end else begin
                            hold_d = hold_q - HoldW'(1);
                        end
                    end
                    GateRelease: begin
                        if (env >= thr_open) begin
                            state_d = GateAttack;
                        end else if (32'(gain_q) <= RELEASE_STEP) begin
                            gain_d  = '0;
                            state_d = GateClosed;
                        end else begin
                            gain_d = gain_q - 9'(RELEASE_STEP);
                        end
                    end
                    default: state_d = GateClosed;
                endcase
            end
        end
        gate_open_d = (state_d == GateAttack) || (state_d == GateOpen) || (state_d == GateHold);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= GateClosed;
            gain_q      <= '0;
            hold_q      <= '0;
            valid_q     <= 1'b0;
            sample_q    <= '0;
            gate_open_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gain_q      <= gain_d;
            hold_q      <= hold_d;
            valid_q     <= valid_d;
            sample_q    <= sample_d;
            gate_open_q <= gate_open_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_sample    = sample_q;
    assign o_gate_open = gate_open_q;

endmodule

// File: tb/tb_noise_gate.sv
// Randomized and directed bench for noise_gate against an integer-arithmetic behavioural model.
module tb_noise_gate;

    localparam int Hold    = 480;
    localparam int Attack  = 32;
    localparam int Release = 1;
    localparam int Shift   = 4;

    localparam int ModeClosed  = 0;
    localparam int ModeAttack  = 1;
    localparam int ModeOpen    = 2;
    localparam int ModeHold    = 3;
    localparam int ModeRelease = 4;

    logic               clk    = 1'b0;
    logic               rst    = 1'b1;
    logic [2:0]         level  = 3'd0;
    logic               valid  = 1'b0;
    logic signed [15:0] sample = '0;
    logic               ready  = 1'b1;
    logic               o_ready;
    logic               o_valid;
    logic signed [15:0] o_sample;
    logic               o_gate_open;

    noise_gate #(
        .HOLD_SAMPLES (Hold),
        .ATTACK_STEP  (Attack),
        .RELEASE_STEP (Release),
        .ENV_SHIFT    (Shift)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_level     (level),
        .i_valid     (valid),
        .i_sample    (sample),
        .o_ready     (o_ready),
        .o_valid     (o_valid),
        .o_sample    (o_sample),
        .i_ready     (ready),
        .o_gate_open (o_gate_open)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    int m_env, m_gain, m_mode, m_hold, m_osample;
    bit m_ovalid;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int floor_div(input int p, input int d);
        if (p >= 0) return p / d;
        return -((-p + d - 1) / d);
    endfunction

    task automatic model_reset();
        m_env     = 0;
        m_gain    = 0;
        m_mode    = ModeClosed;
        m_hold    = 0;
        m_ovalid  = 0;
        m_osample = 0;
    endtask

    // Gate rules on one accepted sample; decisions use the envelope before it absorbs the sample.
    task automatic model_accept(input int lvl, input int s);
        int a, thr, cls, g;
        thr = 32 * (2 ** lvl);
        cls = (thr * 3) / 4;
        g   = (lvl == 0) ? 256 : m_gain;
        m_osample = floor_div(s * g, 256);
        a = (s >= 0) ? s : ((s == -32768) ? 32767 : -s);
        if (lvl == 0) begin
            m_mode = ModeOpen;
            m_gain = 256;
        end else begin
            case (m_mode)
                ModeClosed: if (m_env >= thr) m_mode = ModeAttack;
                ModeAttack: begin
                    m_gain = (m_gain + Attack > 256) ? 256 : m_gain + Attack;
                    if (m_gain == 256) m_mode = ModeOpen;
                end
                ModeOpen: if (m_env < cls) begin
                    m_mode = ModeHold;
                    m_hold = Hold - 1;
                end
                ModeHold: begin
                    if (m_env >= thr) m_mode = ModeOpen;
                    else if (m_hold == 0) m_mode = ModeRelease;
                    else m_hold--;
                end
                ModeRelease: begin
                    if (m_env >= thr) m_mode = ModeAttack;
                    else begin
                        m_gain = (m_gain - Release < 0) ? 0 : m_gain - Release;
                        if (m_gain == 0) m_mode = ModeClosed;
                    end
                end
                default: m_mode = ModeClosed;
            endcase
        end
        m_env = m_env + floor_div(a - m_env, 2 ** Shift);
    endtask

    function automatic int gate_is_open();
        return (m_mode == ModeAttack || m_mode == ModeOpen || m_mode == ModeHold) ? 1 : 0;
    endfunction

    // One clock: handshake checked mid-cycle, registered outputs checked just after the edge.
    task automatic cyc();
        bit m_ready, acc;
        @(negedge clk);
        m_ready = !m_ovalid || ready;
        check_eq("o_ready", int'(o_ready), int'(m_ready));
        acc = valid && m_ready;
        @(posedge clk);
        #1;
        if (rst) model_reset();
        else if (acc) begin
            model_accept(int'(level), int'(sample));
            m_ovalid = 1;
        end else if (ready) m_ovalid = 0;
        check_eq("o_valid", int'(o_valid), int'(m_ovalid));
        check_eq("o_sample", int'(o_sample), m_osample);
        check_eq("gate_open", int'(o_gate_open), gate_is_open());
    endtask

    task automatic feed(input int n, input int lvl, input int smp);
        for (int i = 0; i < n; i++) begin
            rst    = 1'b0;
            level  = 3'(lvl);
            valid  = 1'b1;
            ready  = 1'b1;
            sample = 16'(smp);
            cyc();
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        ready = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int amp_class;
        model_reset();
        do_reset();
        check_eq("reset_gate", int'(o_gate_open), 0);
        check_eq("reset_valid", int'(o_valid), 0);
        check_eq("reset_sample", int'(o_sample), 0);

        // Bypass passes samples bit-exact with one cycle latency.
        feed(1, 0, 1000);
        check_eq("bypass_1000", int'(o_sample), 1000);
        feed(1, 0, -32768);
        check_eq("bypass_min", int'(o_sample), -32768);
        check_eq("bypass_open", int'(o_gate_open), 1);
        for (int i = 0; i < 20; i++) feed(1, 0, int'($signed(16'($urandom))));

        // Open ramp on a steady tone.
        do_reset();
        feed(40, 1, 2000);
        check_eq("ramp_end", int'(o_sample), 2000);
        check_eq("ramp_open", int'(o_gate_open), 1);

        // Silence: decay, hold, release, closed.
        feed(900, 1, 0);
        check_eq("closed_gate", int'(o_gate_open), 0);
        check_eq("closed_sample", int'(o_sample), 0);

        // A burst during hold reopens with full gain.
        feed(40, 1, 2000);
        feed(100, 1, 0);
        check_eq("in_hold", int'(o_gate_open), 1);
        for (int i = 0; i < 5; i++) begin
            feed(1, 1, 2000);
            check_eq("burst_gain", int'(o_sample), 2000);
            check_eq("burst_open", int'(o_gate_open), 1);
        end

        // Backpressure: five stalled cycles, then one sample per ready cycle.
        feed(1, 1, 1234);
        ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sample = 16'($urandom);
            cyc();
            check_eq("stall_hold", int'(o_sample), 1234);
        end
        for (int i = 0; i < 10; i++) feed(1, 1, int'($signed(16'($urandom_range(0, 4000)))));

        // Randomized traffic with shifting levels and loudness.
        for (int seg = 0; seg < 60; seg++) begin
            level     = 3'($urandom_range(0, 7));
            amp_class = $urandom_range(0, 2);
            for (int i = 0; i < 40; i++) begin
                rst   = 1'b0;
                valid = ($urandom_range(0, 3) != 0);
                ready = ($urandom_range(0, 3) != 0);
                if (amp_class == 0) sample = 16'($urandom);
                else if (amp_class == 1) sample = 16'(int'($urandom_range(0, 80)) - 40);
                else sample = ($urandom_range(0, 7) == 0) ? 16'sh8000 : 16'sd5000;
                cyc();
            end
        end

        // Reset during attack with an output pending discards it.
        do_reset();
        feed(4, 1, 2000);
        check_eq("attack_open", int'(o_gate_open), 1);
        valid = 1'b1;
        ready = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        check_eq("rst_valid", int'(o_valid), 0);
        check_eq("rst_gate", int'(o_gate_open), 0);
        feed(1, 7, 100);
        check_eq("rst_gain0", int'(o_sample), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
